flexbex_sram_arbiter: RTL and testbench

Parametrised N-port arbiter and protocol bridge between Ibex-style memory request ports (req/gnt/rvalid) and a single `sky130_sram_1kbyte_1rw1r_32x256_8`-class RW port. It replaces the direct core-to-macro wiring and its constant `rvalid=1`. It generates real grants, a latency-accurate `rvalid` for reads and writes, and an error response for out-of-range addresses. Typical use: Ibex data port plus one or more eFPGA user-IO masters sharing the data SRAM.

---
 rtl/flexbex_sram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_flexbex_sram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexbex_sram_arbiter.sv
// rtl/flexbex_sram_arbiter.sv - N-port req/gnt/rvalid arbiter and bridge onto one RW port of an SRAM macro
module flexbex_sram_arbiter #(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 256,
    parameter int ARB_MODE     = 1,
    parameter int READ_LATENCY = 1,
    localparam int BE_W        = DATA_W / 8,
    localparam int WIDX_W      = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS-1:0]        we_i,
    input  logic [NUM_PORTS*BE_W-1:0]   be_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]        gnt_o,
    output logic [NUM_PORTS-1:0]        rvalid_o,
    output logic                        err_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        sram_csb_o,
    output logic                        sram_web_o,
    output logic [BE_W-1:0]             sram_wmask_o,
    output logic [WIDX_W-1:0]           sram_addr_o,
    output logic [DATA_W-1:0]           sram_din_o,
    input  logic [DATA_W-1:0]           sram_dout_i
);

    localparam int ID_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WORD_W = ADDR_W - 2;
    localparam int LAST   = READ_LATENCY - 1;

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      rr_next;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      sel;
    logic [ID_W:0]        cand_sum;
    logic [ID_W-1:0]      cand;
    logic                 any_gnt;
    logic [NUM_PORTS-1:0] in_range;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_range[p] = 64'(addr_i[p*ADDR_W+2 +: WORD_W]) < 64'(DEPTH);
        end
    end

    // Candidate order starts at rr_ptr in round-robin mode, at 0 in fixed mode;
    // rr_ptr < NUM_PORTS so a single wrap subtraction is enough.
    always_comb begin
        any_gnt  = 1'b0;
        win_id   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_sum = (ARB_MODE == 1) ? ({1'b0, rr_ptr} + (ID_W+1)'(i)) : (ID_W+1)'(i);
            if (cand_sum >= (ID_W+1)'(NUM_PORTS)) begin
                cand_sum = cand_sum - (ID_W+1)'(NUM_PORTS);
            end
            cand = cand_sum[ID_W-1:0];
            if (!any_gnt && req_i[cand]) begin
                any_gnt = 1'b1;
                win_id  = cand;
            end
        end
        if (reset) begin
            any_gnt = 1'b0;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (any_gnt) begin
            gnt_o[win_id] = 1'b1;
        end
    end

    assign rr_next = (win_id == ID_W'(NUM_PORTS - 1)) ? '0 : win_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (any_gnt) begin
            rr_ptr <= rr_next;
        end
    end

    // Idle cycles steer the macro inputs from port 0.
    assign sel = any_gnt ? win_id : '0;

    always_comb begin
        sram_csb_o   = !(any_gnt && in_range[sel]);
        sram_web_o   = any_gnt ? !we_i[sel] : 1'b1;
        sram_wmask_o = be_i[int'(sel)*BE_W +: BE_W];
        sram_addr_o  = addr_i[int'(sel)*ADDR_W+2 +: WIDX_W];
        sram_din_o   = wdata_i[int'(sel)*DATA_W +: DATA_W];
    end

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_err;
    logic [READ_LATENCY-1:0] pipe_we;
    logic [ID_W-1:0]         pipe_id [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            pipe_we    <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_id[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= any_gnt;
            pipe_err[0]   <= any_gnt && !in_range[sel];
            pipe_we[0]    <= we_i[sel];
            pipe_id[0]    <= sel;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_err[s]   <= pipe_err[s-1];
                pipe_we[s]    <= pipe_we[s-1];
                pipe_id[s]    <= pipe_id[s-1];
            end
        end
    end

    logic [DATA_W-1:0] rd_src;

    generate
        if (READ_LATENCY >= 2) begin : g_rd_reg
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= sram_dout_i;
                end
            end
            assign rd_src = dout_q;
        end else begin : g_rd_comb
            assign rd_src = sram_dout_i;
        end
    endgenerate

    // Gating with reset drops a response that would otherwise appear in the
    // same cycle reset is asserted.
    always_comb begin
        rvalid_o = '0;
        err_o    = 1'b0;
        rdata_o  = '0;
        if (pipe_valid[LAST] && !reset) begin
            rvalid_o[pipe_id[LAST]] = 1'b1;
            err_o                   = pipe_err[LAST];
            if (!pipe_err[LAST] && !pipe_we[LAST]) begin
                rdata_o = rd_src;
            end
        end
    end

endmodule

// File: tb/tb_flexbex_sram_arbiter.sv
// tb/tb_flexbex_sram_arbiter.sv - directed scoreboard bench for flexbex_sram_arbiter
module tb_flexbex_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_a, req_b, req_c;
    logic [1:0]  we_v;
    logic [7:0]  be_v;
    logic [23:0] addr_v;
    logic [63:0] wdata_v;

    logic [1:0]  gnt_a, gnt_b, gnt_c;
    logic [1:0]  rvalid_a, rvalid_b, rvalid_c;
    logic        err_a, err_b, err_c;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        csb_a, csb_b, csb_c;
    logic        web_a, web_b, web_c;
    logic [3:0]  wmask_a, wmask_b, wmask_c;
    logic [7:0]  saddr_a, saddr_b, saddr_c;
    logic [31:0] din_a, din_b, din_c;
    logic [31:0] dout_a, dout_b, dout_c;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] mem_c [256];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          due;
        int          id;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sbq [$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flexbex_sram_arbiter #(.ARB_MODE(1), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .req_i(req_a), .we_i(we_v), .be_i(be_v),
        .addr_i(addr_v), .wdata_i(wdata_v), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .err_o(err_a), .rdata_o(rdata_a), .sram_csb_o(csb_a), .sram_web_o(web_a),
        .sram_wmask_o(wmask_a), .sram_addr_o(saddr_a), .sram_din_o(din_a),
        .sram_dout_i(dout_a)
    );

    flexbex_sram_arbiter #(.ARB_MODE(0), .READ_LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .req_i(req_b), .we_i(we_v), .be_i(be_v),
        .addr_i(addr_v), .wdata_i(wdata_v), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .err_o(err_b), .rdata_o(rdata_b), .sram_csb_o(csb_b), .sram_web_o(web_b),
        .sram_wmask_o(wmask_b), .sram_addr_o(saddr_b), .sram_din_o(din_b),
        .sram_dout_i(dout_b)
    );

    flexbex_sram_arbiter #(.ARB_MODE(1), .READ_LATENCY(2)) dut_c (
        .clk(clk), .reset(reset), .req_i(req_c), .we_i(we_v), .be_i(be_v),
        .addr_i(addr_v), .wdata_i(wdata_v), .gnt_o(gnt_c), .rvalid_o(rvalid_c),
        .err_o(err_c), .rdata_o(rdata_c), .sram_csb_o(csb_c), .sram_web_o(web_c),
        .sram_wmask_o(wmask_c), .sram_addr_o(saddr_c), .sram_din_o(din_c),
        .sram_dout_i(dout_c)
    );

    always @(posedge clk) begin
        if (!csb_a) begin
            if (!web_a) begin
                for (int b = 0; b < 4; b++) if (wmask_a[b]) mem_a[saddr_a][b*8 +: 8] <= din_a[b*8 +: 8];
            end else begin
                dout_a <= mem_a[saddr_a];
            end
        end
    end

    always @(posedge clk) begin
        if (!csb_b) begin
            if (!web_b) begin
                for (int b = 0; b < 4; b++) if (wmask_b[b]) mem_b[saddr_b][b*8 +: 8] <= din_b[b*8 +: 8];
            end else begin
                dout_b <= mem_b[saddr_b];
            end
        end
    end

    always @(posedge clk) begin
        if (!csb_c) begin
            if (!web_c) begin
                for (int b = 0; b < 4; b++) if (wmask_c[b]) mem_c[saddr_c][b*8 +: 8] <= din_c[b*8 +: 8];
            end else begin
                dout_c <= mem_c[saddr_c];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                mon_e = sbq.pop_front();
                chk("a_rvalid", 32'(rvalid_a), 32'(1) << mon_e.id);
                chk("a_err", 32'(err_a), 32'(mon_e.err));
                chk("a_rdata", rdata_a, mon_e.data);
            end else begin
                chk("a_rvalid_idle", 32'(rvalid_a), 32'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int p, input logic w, input logic [3:0] b,
                        input logic [11:0] a, input logic [31:0] d);
        we_v[p]           = w;
        be_v[p*4 +: 4]    = b;
        addr_v[p*12 +: 12] = a;
        wdata_v[p*32 +: 32] = d;
    endtask

    task automatic step_a(input logic [1:0] req, input logic [1:0] exp_gnt, input logic exp_csb,
                          input logic exp_err, input logic [31:0] exp_data);
        exp_t e;
        req_a = req;
        @(negedge clk);
        chk("a_gnt", 32'(gnt_a), 32'(exp_gnt));
        chk("a_csb", 32'(csb_a), 32'(exp_csb));
        if (exp_gnt == 2'b00) begin
            chk("a_web_idle", 32'(web_a), 32'(1));
        end else begin
            e.due  = cyc + 1;
            e.id   = exp_gnt[1] ? 1 : 0;
            e.err  = exp_err;
            e.data = exp_data;
            sbq.push_back(e);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            mem_c[i] = '0;
        end
        dout_a = '0; dout_b = '0; dout_c = '0;
        reset = 1'b1;
        req_a = 2'b11; req_b = 2'b00; req_c = 2'b00;
        we_v = '0; be_v = '0; addr_v = '0; wdata_v = '0;
        setp(0, 1'b0, 4'hF, 12'h010, 32'h0);
        setp(1, 1'b0, 4'hF, 12'h020, 32'h0);
        mon_en = 1'b1;

        tick();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt_a), 32'(0));
        chk("rst_csb", 32'(csb_a), 32'(1));
        chk("rst_web", 32'(web_a), 32'(1));
        chk("rst_err", 32'(err_a), 32'(0));
        chk("rst_rdata", rdata_a, 32'(0));
        tick();
        reset = 1'b0;

        // port 0 first after reset, then write/read and byte-mask traffic
        step_a(2'b11, 2'b01, 1'b0, 1'b0, 32'h0);
        setp(0, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF);
        step_a(2'b01, 2'b01, 1'b0, 1'b0, 32'h0);
        setp(0, 1'b0, 4'hF, 12'h010, 32'h0);
        step_a(2'b01, 2'b01, 1'b0, 1'b0, 32'hDEADBEEF);
        setp(0, 1'b1, 4'hF, 12'h014, 32'h11223344);
        step_a(2'b01, 2'b01, 1'b0, 1'b0, 32'h0);
        setp(0, 1'b1, 4'b0101, 12'h014, 32'hAABBCCDD);
        step_a(2'b01, 2'b01, 1'b0, 1'b0, 32'h0);
        setp(0, 1'b0, 4'hF, 12'h014, 32'h0);
        step_a(2'b01, 2'b01, 1'b0, 1'b0, 32'h11BB33DD);

        // lone port 1 request moves the pointer back to 0, then alternate
        setp(1, 1'b0, 4'hF, 12'h014, 32'h0);
        step_a(2'b10, 2'b10, 1'b0, 1'b0, 32'h11BB33DD);
        setp(0, 1'b0, 4'hF, 12'h010, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step_a(2'b11, 2'b01, 1'b0, 1'b0, 32'hDEADBEEF);
            step_a(2'b11, 2'b10, 1'b0, 1'b0, 32'h11BB33DD);
        end

        // out-of-range read on port 0, out-of-range write on port 1
        setp(0, 1'b0, 4'hF, 12'h400, 32'h0);
        step_a(2'b01, 2'b01, 1'b1, 1'b1, 32'h0);
        setp(1, 1'b1, 4'hF, 12'hFFC, 32'h12345678);
        step_a(2'b10, 2'b10, 1'b1, 1'b1, 32'h0);
        step_a(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
        step_a(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
        chk("a_sb_drained", 32'(sbq.size()), 32'(0));

        // fixed priority: port 0 always wins while both request
        setp(0, 1'b0, 4'hF, 12'h010, 32'h0);
        setp(1, 1'b0, 4'hF, 12'h020, 32'h0);
        for (int k = 0; k < 4; k++) begin
            req_b = 2'b11;
            @(negedge clk);
            chk("b_gnt", 32'(gnt_b), 32'(2'b01));
            chk("b_rvalid", 32'(rvalid_b), (k > 0) ? 32'(2'b01) : 32'(0));
            tick();
        end
        req_b = 2'b10;
        @(negedge clk);
        chk("b_gnt_p1", 32'(gnt_b), 32'(2'b10));
        chk("b_rvalid_last", 32'(rvalid_b), 32'(2'b01));
        tick();
        req_b = 2'b00;
        @(negedge clk);
        chk("b_rvalid_p1", 32'(rvalid_b), 32'(2'b10));
        chk("b_rdata", rdata_b, 32'(0));
        tick();

        // latency 2: out-of-range read
        setp(0, 1'b0, 4'hF, 12'h400, 32'h0);
        req_c = 2'b01;
        @(negedge clk);
        chk("c_gnt_oor", 32'(gnt_c), 32'(2'b01));
        chk("c_csb_oor", 32'(csb_c), 32'(1));
        tick();
        req_c = 2'b00;
        @(negedge clk);
        chk("c_rvalid_t1", 32'(rvalid_c), 32'(0));
        tick();
        @(negedge clk);
        chk("c_rvalid_t2", 32'(rvalid_c), 32'(2'b01));
        chk("c_err_t2", 32'(err_c), 32'(1));
        chk("c_rdata_t2", rdata_c, 32'(0));
        tick();

        // latency 2: write then read the same word
        setp(0, 1'b1, 4'hF, 12'h020, 32'hCAFEF00D);
        req_c = 2'b01;
        tick();
        setp(0, 1'b0, 4'hF, 12'h020, 32'h0);
        @(negedge clk);
        chk("c_rvalid_wr_t1", 32'(rvalid_c), 32'(0));
        tick();
        req_c = 2'b00;
        @(negedge clk);
        chk("c_rvalid_wr", 32'(rvalid_c), 32'(2'b01));
        chk("c_rdata_wr", rdata_c, 32'(0));
        tick();
        @(negedge clk);
        chk("c_rvalid_rd", 32'(rvalid_c), 32'(2'b01));
        chk("c_err_rd", 32'(err_c), 32'(0));
        chk("c_rdata_rd", rdata_c, 32'hCAFEF00D);
        tick();

        // reset one cycle after a grant drops the response
        req_c = 2'b01;
        @(negedge clk);
        chk("c_gnt_pre_rst", 32'(gnt_c), 32'(2'b01));
        tick();
        req_c = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        chk("c_rvalid_in_rst", 32'(rvalid_c), 32'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("c_rvalid_drop", 32'(rvalid_c), 32'(0));
        tick();
        @(negedge clk);
        chk("c_rvalid_drop2", 32'(rvalid_c), 32'(0));
        tick();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
